// File: rtl/instr_encoder_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_if
// Field-bundle stream into the instruction encoder and the instruction-memory
// write bus coming out of it.
//
//   in_valid / in_ready : stream handshake, a bundle moves when both are high
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm : bundle
//   wr_en / wr_addr / wr_data : one-cycle imem write strobe, word address, word
//
// master : the bundle source and imem side (loader or bench)
// slave  : the encoder
// -----------------------------------------------------------------------------
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
               in_funct7, in_imm,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
               in_funct7, in_imm,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Packs an opcode, register fields and a signed immediate into an RV32I word
// and writes each legal word into instruction memory at an auto-incrementing
// word address. Immediates arrive in the immediate generator's units: B and J
// in halfwords (no implicit zero LSB), U as the raw 20-bit field value.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : pulse, reload address from base_addr, clear full and err_cnt
//   base_addr  : first write address after start
//   bus        : field stream in, imem write bus out (instr_encoder_if.slave)
//   full       : address space exhausted, cleared only by start or rst
//   err_valid  : one-cycle pulse when a bundle is rejected
//   err_code   : 01 bad opcode, 10 immediate out of range; held until next error
//   err_cnt    : rejected bundles, saturating at 255
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    instr_encoder_if.slave    bus,
    output logic              full,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic [7:0]        err_cnt
);

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_R,
        FMT_BAD
    } fmt_e;

    fmt_e              w_fmt;
    logic              w_imm12_ok;
    logic              w_imm20_ok;
    logic              w_imm_ok;
    logic [31:0]       w_word;
    logic              w_accept;

    logic [ADDR_W-1:0] r_addr;
    logic              r_full;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_wr_data;
    logic              r_err_valid;
    logic [1:0]        r_err_code;
    logic [7:0]        r_err_cnt;

    // start wins over an offered bundle; the source simply holds it.
    assign bus.in_ready = !rst && !r_full && !start;
    assign w_accept     = bus.in_valid && bus.in_ready;

    always_comb begin
        w_fmt = FMT_BAD;
        case (bus.in_opcode)
            7'b0010011,
            7'b0000011: w_fmt = FMT_I;
            7'b0100011: w_fmt = FMT_S;
            7'b1100011: w_fmt = FMT_B;
            7'b0110111: w_fmt = FMT_U;
            7'b1101111: w_fmt = FMT_J;
            7'b0110011: w_fmt = FMT_R;
            default:    w_fmt = FMT_BAD;
        endcase
    end

    // An immediate fits when every bit above the field's sign bit copies it.
    assign w_imm12_ok = (&bus.in_imm[31:11]) || !(|bus.in_imm[31:11]);
    assign w_imm20_ok = (&bus.in_imm[31:19]) || !(|bus.in_imm[31:19]);

    always_comb begin
        w_imm_ok = 1'b1;
        case (w_fmt)
            FMT_I, FMT_S, FMT_B: w_imm_ok = w_imm12_ok;
            FMT_U, FMT_J:        w_imm_ok = w_imm20_ok;
            default:             w_imm_ok = 1'b1;
        endcase
    end

    always_comb begin
        w_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                  bus.in_rd, bus.in_opcode};
        case (w_fmt)
            FMT_I: w_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3,
                             bus.in_rd, bus.in_opcode};
            FMT_S: w_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1,
                             bus.in_funct3, bus.in_imm[4:0], bus.in_opcode};
            // Halfword units: imm[k] lands where the byte offset's bit k+1 goes.
            FMT_B: w_word = {bus.in_imm[11], bus.in_imm[9:4], bus.in_rs2,
                             bus.in_rs1, bus.in_funct3, bus.in_imm[3:0],
                             bus.in_imm[10], bus.in_opcode};
            FMT_U: w_word = {bus.in_imm[19:0], bus.in_rd, bus.in_opcode};
            FMT_J: w_word = {bus.in_imm[19], bus.in_imm[9:0], bus.in_imm[10],
                             bus.in_imm[18:11], bus.in_rd, bus.in_opcode};
            default: w_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1,
                               bus.in_funct3, bus.in_rd, bus.in_opcode};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_full      <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_err_valid <= 1'b0;
            r_err_code  <= 2'b00;
            r_err_cnt   <= 8'd0;
        end else begin
            r_wr_en     <= 1'b0;
            r_err_valid <= 1'b0;
            if (start) begin
                r_addr    <= base_addr;
                r_full    <= 1'b0;
                r_err_cnt <= 8'd0;
            end else if (w_accept) begin
                if (w_fmt != FMT_BAD && w_imm_ok) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_addr;
                    r_wr_data <= w_word;
                    r_addr    <= r_addr + 1'b1;
                    // Writing the top word wraps the counter; stop taking input.
                    if (&r_addr) begin
                        r_full <= 1'b1;
                    end
                end else begin
                    r_err_valid <= 1'b1;
                    r_err_code  <= (w_fmt == FMT_BAD) ? 2'b01 : 2'b10;
                    if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end
            end
        end
    end

    assign bus.wr_en   = r_wr_en;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_wr_data;
    assign full        = r_full;
    assign err_valid   = r_err_valid;
    assign err_code    = r_err_code;
    assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          full;
    logic          err_valid;
    logic [1:0]    err_code;
    logic [7:0]    err_cnt;

    instr_encoder_if #(.ADDR_W(AW)) bus ();

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .bus       (bus),
        .full      (full),
        .err_valid (err_valid),
        .err_code  (err_code),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    bit rand_start = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Format codes: 0 I, 1 S, 2 B, 3 U, 4 J, 5 R, -1 illegal opcode.
    function automatic int fmt_of(input logic [6:0] op);
        case (op)
            7'h13, 7'h03: return 0;
            7'h23:        return 1;
            7'h63:        return 2;
            7'h37:        return 3;
            7'h6F:        return 4;
            7'h33:        return 5;
            default:      return -1;
        endcase
    endfunction

    function automatic bit imm_fits(input int f, input logic [31:0] imm);
        int v;
        v = int'(imm);
        if (f <= 2) return (v >= -2048) && (v <= 2047);
        if (f <= 4) return (v >= -524288) && (v <= 524287);
        return 1'b1;
    endfunction

    // Reference encoder: works from the architectural byte offset (imm * 2)
    // for B and J, as the ISA manual lays the bits out.
    function automatic logic [31:0] encode(input int f, input logic [6:0] op,
                                           input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [31:0] imm);
        logic [31:0] off;
        off = imm << 1;
        case (f)
            0: return {imm[11:0], rs1, f3, rd, op};
            1: return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            2: return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], op};
            3: return {imm[19:0], rd, op};
            4: return {off[20], off[10:1], off[11], off[19:12], rd, op};
            default: return {f7, rs2, rs1, f3, rd, op};
        endcase
    endfunction

    // Immediate generator: extracts the immediate back out of a word.
    function automatic logic [31:0] immgen(input int f, input logic [31:0] w);
        logic [31:0] b;
        case (f)
            0: return {{20{w[31]}}, w[31:20]};
            1: return {{20{w[31]}}, w[31:25], w[11:7]};
            2: begin
                b = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
                return $signed(b) >>> 1;
            end
            3: return {{12{w[31]}}, w[31:12]};
            4: begin
                b = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
                return $signed(b) >>> 1;
            end
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    int          m_addr = 0;
    bit          m_full = 1'b0;
    bit          e_wr_en = 1'b0;
    int          e_addr = 0;
    logic [31:0] e_data = '0;
    logic [31:0] e_imm = '0;
    int          e_fmt = 0;
    bit          e_err_valid = 1'b0;
    int          e_code = 0;
    int          e_cnt = 0;

    always @(posedge clk or posedge rst) begin
        int f;
        if (rst) begin
            m_addr = 0; m_full = 1'b0; e_wr_en = 1'b0; e_err_valid = 1'b0;
            e_code = 0; e_cnt = 0;
        end else begin
            e_wr_en = 1'b0;
            e_err_valid = 1'b0;
            if (start) begin
                m_addr = int'(base_addr);
                m_full = 1'b0;
                e_cnt = 0;
            end else if (bus.in_valid && !m_full) begin
                f = fmt_of(bus.in_opcode);
                if (f >= 0 && imm_fits(f, bus.in_imm)) begin
                    e_wr_en = 1'b1;
                    e_addr = m_addr;
                    e_fmt = f;
                    e_imm = bus.in_imm;
                    e_data = encode(f, bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2,
                                    bus.in_funct3, bus.in_funct7, bus.in_imm);
                    m_addr = (m_addr + 1) % (1 << AW);
                    if (m_addr == 0) m_full = 1'b1;
                end else begin
                    e_err_valid = 1'b1;
                    e_code = (f < 0) ? 1 : 2;
                    if (e_cnt < 255) e_cnt++;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #2;
        chk("wr_en", {31'd0, bus.wr_en}, {31'd0, e_wr_en});
        if (e_wr_en) begin
            chk("wr_addr", 32'(bus.wr_addr), 32'(e_addr));
            chk("wr_data", bus.wr_data, e_data);
            if (e_fmt != 5) chk("roundtrip_imm", immgen(e_fmt, bus.wr_data), e_imm);
        end
        chk("err_valid", {31'd0, err_valid}, {31'd0, e_err_valid});
        chk("err_code", 32'(err_code), 32'(e_code));
        chk("err_cnt", 32'(err_cnt), 32'(e_cnt));
        chk("full", {31'd0, full}, {31'd0, m_full});
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, (!rst && !m_full && !start)});
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
        bit acc;
        int budget;
        @(negedge clk);
        bus.in_opcode = op; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
        bus.in_funct3 = f3; bus.in_funct7 = f7; bus.in_imm = imm; bus.in_valid = 1'b1;
        if (rand_start && (m_full || $urandom_range(0, 24) == 0)) begin
            start = 1'b1;
            base_addr = AW'($urandom_range(0, (1 << AW) - 1));
        end
        acc = 1'b0;
        budget = 0;
        while (!acc && budget < 20) begin
            #1 acc = bus.in_ready;
            @(posedge clk);
            if (!acc) begin
                @(negedge clk);
                start = 1'b0;
            end
            budget++;
        end
        if (!acc) chk("accept_timeout", {31'd0, acc}, 32'd1);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic pulse_start(input logic [AW-1:0] b);
        @(negedge clk);
        bus.in_valid = 1'b0;
        start = 1'b1;
        base_addr = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_random_legal();
        logic [6:0] ops [7];
        int k, f, v;
        logic [31:0] imm;
        ops = '{7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h33};
        k = $urandom_range(0, 6);
        f = fmt_of(ops[k]);
        case ($urandom_range(0, 9))
            0: v = (f <= 2) ? -2048 : -524288;
            1: v = (f <= 2) ? 2047 : 524287;
            default: v = (f <= 2) ? int'($urandom_range(0, 4095)) - 2048
                                  : int'($urandom_range(0, 1048575)) - 524288;
        endcase
        imm = (f == 5) ? $urandom() : 32'(v);
        send(ops[k], 5'($urandom()), 5'($urandom()), 5'($urandom()), 3'($urandom()),
             7'($urandom()), imm);
    endtask

    task automatic send_random_bad();
        logic [6:0] op;
        op = 7'($urandom());
        if ($urandom_range(0, 1) == 0) begin
            while (fmt_of(op) >= 0) op = 7'($urandom());
        end else begin
            op = ($urandom_range(0, 1) == 0) ? 7'h63 : 7'h6F;
        end
        // A full 32-bit random immediate almost never fits; the model decides.
        send(op, 5'($urandom()), 5'($urandom()), 5'($urandom()), 3'($urandom()),
             7'($urandom()), $urandom());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_rd = '0; bus.in_rs1 = '0;
        bus.in_rs2 = '0; bus.in_funct3 = '0; bus.in_funct7 = '0; bus.in_imm = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("rst_wr_data", bus.wr_data, 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;

        // Directed words.
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
        #2;
        chk("addi_addr", 32'(bus.wr_addr), 32'd0);
        chk("addi_data", bus.wr_data, 32'hFFF00093);
        send(7'h23, 5'd0, 5'd3, 5'd2, 3'b010, 7'd0, 32'd8);
        #2;
        chk("sw_addr", 32'(bus.wr_addr), 32'd1);
        chk("sw_data", bus.wr_data, 32'h0021A423);
        send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
        #2;
        chk("jal_addr", 32'(bus.wr_addr), 32'd2);
        chk("jal_data", bus.wr_data, 32'hFFFFF0EF);
        send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h00000800);
        #2;
        chk("beq_err_valid", {31'd0, err_valid}, 32'd1);
        chk("beq_err_code", 32'(err_code), 32'd2);
        chk("beq_err_cnt", 32'(err_cnt), 32'd1);
        chk("beq_no_write", {31'd0, bus.wr_en}, 32'd0);
        send(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        #2;
        chk("badop_err_code", 32'(err_code), 32'd1);
        chk("badop_err_cnt", 32'(err_cnt), 32'd2);

        // Fill the four-word space back to back.
        pulse_start(2'd0);
        chk("start_clears_cnt", 32'(err_cnt), 32'd0);
        for (int i = 0; i < 4; i++) send(7'h13, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
        #2;
        chk("full_set", {31'd0, full}, 32'd1);
        chk("full_ready_low", {31'd0, bus.in_ready}, 32'd0);
        idle();
        pulse_start(2'd2);
        send(7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
        #2;
        chk("restart_addr", 32'(bus.wr_addr), 32'd2);
        chk("restart_full", {31'd0, full}, 32'd0);
        idle();

        // Randomized stream, including start pulses that collide with bundles.
        rand_start = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 7) == 0) send_random_bad();
            send_random_legal();
            if ($urandom_range(0, 5) == 0) idle();
        end
        rand_start = 1'b0;
        idle();

        // Error counter saturation.
        pulse_start(2'd0);
        for (int n = 0; n < 260; n++) send(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        idle();
        chk("err_cnt_sat", 32'(err_cnt), 32'd255);

        // Reset while a write is on the bus.
        send(7'h13, 5'd3, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1);
        #1;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("rst_drops_wr_en", {31'd0, bus.wr_en}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("post_rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("post_rst_err_cnt", 32'(err_cnt), 32'd0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the core's immediate generator: packs opcode, register fields and a signed immediate into a 32-bit RV32I instruction word.
- Accepts fields over a valid/ready stream, range-checks the immediate, and writes each legal word to instruction memory at an auto-incrementing address. Used as the program loader and bench stimulus source.
- Immediates use the same units the immediate generator outputs: B and J in halfword units (no implicit zero LSB), U unshifted (the 20-bit field value). Round trip: the generator applied to any written word returns in_imm.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity is 2^ADDR_W words.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; reload write address from base_addr and clear full/err_cnt
- base_addr  in  ADDR_W  first write address after start
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept
- in_opcode  in  7  opcode
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3
- in_funct7  in  7  used by R-type only
- in_imm  in  32  immediate, generator units
- wr_en  out  1  imem write strobe
- wr_addr  out  ADDR_W  imem word address
- wr_data  out  32  encoded instruction
- full  out  1  address space exhausted
- err_valid  out  1  one-cycle pulse: bundle rejected
- err_code  out  2  01 bad opcode, 10 imm out of range; held until next error
- err_cnt  out  8  rejected bundles, saturates at 255

Behaviour:
- Reset (async): wr_en=0, wr_addr=0, wr_data=0, full=0, err_valid=0, err_code=0, err_cnt=0, internal address counter=0. in_ready=0 while rst is high.
- in_ready = !full && !start. Accept when in_valid && in_ready. start has priority: a bundle presented with start is not accepted and the source holds it.
- Opcode to format mapping: 0010011 and 0000011 are I; 0100011 is S; 1100011 is B; 0110111 is U; 1101111 is J; 0110011 is R. Any other opcode gives err 01.
- Range checks (fail gives err 10). In_imm must sign-extend from:
  - I, S, B: bit 11.
  - U, J: bit 19.
  - R: in_imm ignored.
- Packing, with common fields opcode at [6:0], rd at [11:7], funct3 at [14:12], rs1 at [19:15], rs2 at [24:20]:
  - I: [31:20]=imm[11:0]; rs2 field not used.
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[11], [7]=imm[10], [30:25]=imm[9:4], [11:8]=imm[3:0].
  - U: [31:12]=imm[19:0], plus rd and opcode.
  - J: [31]=imm[19], [30:21]=imm[9:0], [20]=imm[10], [19:12]=imm[18:11], plus rd and opcode.
  - R: [31:25]=funct7.
- Legal accept in cycle N: at edge N+1, wr_en=1 for exactly one cycle, wr_data = packed word, wr_addr = counter. Counter then increments. Latency 1 cycle; back-to-back accepts give one write per cycle.
- Rejected accept: no write and counter unchanged. err_valid pulses at N+1; err_code updates; err_cnt increments (saturating).
- Full:
  - After the write to address 2^ADDR_W-1 the counter wraps to 0 and full=1 from that cycle.
  - in_ready drops the cycle after the last accept, so no silent wrap occurs.
  - Only start or rst clears full.
- start: counter=base_addr, full=0, err_cnt=0 on the next edge. A write already registered from the prior cycle still completes at its old address.
- rst mid-write: wr_en drops immediately (async); the pending word is discarded.

Test Plan:
- ADDI: opcode 0010011, rd=1, rs1=0, funct3=0, imm=32'hFFFFFFFF -> one cycle later wr_en=1, wr_addr=0, wr_data=32'hFFF00093.
- SW: opcode 0100011, rs1=3, rs2=2, funct3=010, imm=8 -> wr_data=32'h0021A423; JAL rd=1, imm=32'hFFFFFFFF -> wr_data=32'hFFFFF0EF at the next address.
- BEQ imm=32'h00000800 -> err_valid pulse, err_code=10, err_cnt=1, no wr_en, address unchanged; opcode 1111111 -> err_code=01.
- Round trip: 1000 random legal bundles over all six formats -> the immediate generator model applied to wr_data equals in_imm for non-R formats; addresses contiguous.
- ADDR_W=2: 4 back-to-back accepts -> addresses 0,1,2,3, then full=1, in_ready=0. start with base_addr=2 -> next write at 2, full=0.
- Assert rst in the cycle after an accept -> wr_en=0 immediately; after release, in_ready=1, wr_addr=0, err_cnt=0.
